// File: rtl/my_top_level_if.sv
// Operand/result bundle for the registered adder: two addends in, one sum out.
interface my_top_level_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] io_A;
    logic [WIDTH-1:0] io_B;
    logic [WIDTH-1:0] io_X;

    modport master (
        output io_A,
        output io_B,
        input  io_X
    );

    modport slave (
        input  io_A,
        input  io_B,
        output io_X
    );
endinterface

// File: rtl/my_top_level.sv
// Registered unsigned adder: io_X loads (io_A + io_B) mod 2^WIDTH every rising edge.
// Synchronous active-high reset clears the result register and wins over the sum.
module my_top_level #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    my_top_level_if.slave bus
);
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    // Carry-out is intentionally dropped; the sum wraps modulo 2^WIDTH.
    always_comb begin
        sum_d = bus.io_A + bus.io_B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.io_X = sum_q;
endmodule

// File: tb/tb_my_top_level.sv
// Scoreboard bench for my_top_level: stimulus pushes expected sums, a monitor pops and
// compares one cycle later; io_X is also checked for stability before each edge.
module tb_my_top_level;
    localparam int unsigned WIDTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    my_top_level_if #(.WIDTH(WIDTH)) bus ();

    my_top_level #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] x;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp     = 0;
    int         n_bad     = 0;
    logic [7:0] last_x    = 8'h00;
    bit         have_last = 1'b0;

    // Drive one cycle of inputs on the falling edge, confirm io_X has not moved yet,
    // then queue the value io_X must show after the coming rising edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r,
                        input string name);
        @(negedge clk);
        bus.io_A = a;
        bus.io_B = b;
        reset    = r;
        #1;
        if (have_last) begin
            n_cmp++;
            if (bus.io_X !== last_x) begin
                n_bad++;
                $display("FAIL hold_before_%s: io_X=%h required %h", name, bus.io_X, last_x);
            end
        end
        last_x    = r ? 8'h00 : 8'(a + b);
        have_last = 1'b1;
        exp_q.push_back('{x: last_x, name: name});
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (bus.io_X !== mon_e.x) begin
                n_bad++;
                $display("FAIL %s: io_X=%h required %h", mon_e.name, bus.io_X, mon_e.x);
            end
        end
    end

    initial begin
        bus.io_A = 8'h00;
        bus.io_B = 8'h00;

        step(8'h55, 8'h22, 1'b1, "reset_edge0");
        step(8'h55, 8'h22, 1'b1, "reset_edge1");

        step(8'h03, 8'h04, 1'b0, "sum_3_4");

        step(8'hFF, 8'h01, 1'b0, "wrap_ff_01");
        step(8'hFF, 8'hFF, 1'b0, "wrap_ff_ff");
        step(8'h80, 8'h80, 1'b0, "wrap_80_80");

        step(8'h01, 8'h01, 1'b0, "b2b_1_1");
        step(8'h02, 8'h02, 1'b0, "b2b_2_2");
        step(8'h10, 8'hF0, 1'b0, "b2b_10_f0");

        step(8'h10, 8'h20, 1'b0, "midrst_pre0");
        step(8'h10, 8'h20, 1'b0, "midrst_pre1");
        step(8'h10, 8'h20, 1'b1, "midrst_pulse");
        step(8'h10, 8'h20, 1'b0, "midrst_post");

        for (int i = 0; i < 1000; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/my_top_level.md
MY_TOP_LEVEL -- requirements
Module: my_top_level

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of io_A, io_B and io_X.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port io_A, input, WIDTH bits: unsigned addend A.
REQ-005 Port io_B, input, WIDTH bits: unsigned addend B.
REQ-006 Port io_X, output, WIDTH bits: registered unsigned sum of A and B.
REQ-007 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-008 On each rising clk edge with reset low, io_X SHALL load (io_A + io_B) mod 2^WIDTH, using the io_A and io_B values sampled at that edge.
REQ-009 Latency SHALL be exactly 1 clock cycle: a change on io_A or io_B SHALL appear on io_X after the next rising edge, never combinationally.
REQ-010 The addition SHALL be unsigned with wrap-around; the carry-out SHALL be discarded, and no overflow flag SHALL exist.
REQ-011 io_X SHALL be driven only by the output register, with no combinational path from any input to io_X.
REQ-012 Between rising edges, io_X SHALL hold its value regardless of input activity or glitches.
REQ-013 The output register SHALL update every cycle; there is no enable and no handshake.
REQ-014 With inputs held constant, io_X SHALL remain constant from the second post-reset edge onward.
REQ-015 Boundary: io_A = 2^WIDTH-1 and io_B = 1 SHALL produce io_X = 0.
REQ-016 Boundary: io_A = io_B = 2^WIDTH-1 SHALL produce io_X = 2^WIDTH-2.

Reset
REQ-017 When reset is high at a rising edge, io_X SHALL become 0, and reset SHALL take priority over the sum.
REQ-018 While reset stays high, io_X SHALL remain 0 at every edge regardless of io_A and io_B.
REQ-019 If reset asserts mid-operation, io_X SHALL go to 0 at that edge; in-flight results SHALL be lost.
REQ-020 On the first edge with reset low after deassertion, io_X SHALL load the current sum.
REQ-021 Before the first reset edge, io_X SHALL be undefined; the bench SHALL apply reset before checking.
REQ-022 The block SHALL have no asynchronous behaviour on reset.

Verification
REQ-023 Reset: hold reset=1 for 2 cycles with io_A=0x55 and io_B=0x22 -> io_X=0x00 after each edge.
REQ-024 Basic sum: with reset=0, set io_A=3 and io_B=4 -> io_X=7 after the next edge; io_X unchanged before that edge.
REQ-025 Wrap-around: io_A=0xFF with io_B=0x01 -> io_X=0x00; io_A=0xFF with io_B=0xFF -> io_X=0xFE; io_A=0x80 with io_B=0x80 -> io_X=0x00.
REQ-026 Back-to-back: change inputs every cycle over (1,1), (2,2), (0x10,0xF0) -> io_X sequence 2, 4, 0x00, each one cycle after its inputs.
REQ-027 Mid-run reset: with io_A=0x10 and io_B=0x20 (io_X=0x30), pulse reset for 1 cycle -> io_X=0x00, then io_X=0x30 on the next edge.
REQ-028 Random: 1000 random (io_A, io_B) pairs -> io_X equals (A+B) mod 256 from the previous cycle for every cycle.
